// File: rtl/mem_sweep_fill.sv
// mem_sweep_fill: DATA_W x DEPTH register-file memory with a sweep-fill engine,
// a direct single-entry write port and a registered read port.
module mem_sweep_fill #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_drop,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    // DEPTH held one bit wider than an address so the overshoot test cannot wrap
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_n;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] cur, end_q, stride_q;
    logic [DATA_W-1:0] fill_q;
    logic [ADDR_W:0]   nxt;
    logic              load, fill_we, last;

    // Next-state logic, sweep step computation and status outputs
    always_comb begin
        state_n = state;
        load    = 1'b0;
        fill_we = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        nxt     = {1'b0, cur} + {1'b0, stride_q};
        last    = (nxt > {1'b0, end_q}) || (nxt >= DEPTH_X);
        unique case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = (start_addr > end_addr) ? DONE : FILL;
                end
            end
            FILL: begin
                busy    = 1'b1;
                fill_we = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Sweep parameters are latched on start; cur advances while filling
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur      <= '0;
            end_q    <= '0;
            stride_q <= ADDR_W'(1);
            fill_q   <= '0;
        end else if (load) begin
            cur      <= start_addr;
            end_q    <= end_addr;
            stride_q <= (stride == '0) ? ADDR_W'(1) : stride;
            fill_q   <= fill_data;
        end else if (state == FILL && !last) begin
            cur <= nxt[ADDR_W-1:0];
        end
    end

    // Flag a direct write that arrived while the engine owned the memory
    always_ff @(posedge clk) begin
        if (!rst_n) wr_drop <= 1'b0;
        else        wr_drop <= wr_en && (state == FILL);
    end

    // Memory array: fill writes during FILL, direct writes otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (fill_we) begin
            mem[cur] <= fill_q;
        end else if (wr_en && state != FILL) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, read-before-write
    always_ff @(posedge clk) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_mem_sweep_fill.sv
// tb_mem_sweep_fill: directed bench for the sweep-fill memory.
module tb_mem_sweep_fill;

    logic       clk = 1'b0;
    logic       rst_n, start, wr_en;
    logic [3:0] start_addr, end_addr, stride, wr_addr, rd_addr;
    logic [7:0] fill_data, wr_data, rd_data;
    logic       busy, done, wr_drop;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t vecs[16];

    mem_sweep_fill #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .end_addr(end_addr), .stride(stride), .fill_data(fill_data),
        .busy(busy), .done(done), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_drop(wr_drop), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] e, input string name);
        rd_addr = a;
        step();
        check($sformatf("%s rd[%0d]", name, a), int'(rd_data), int'(e));
    endtask

    // Sets every table entry to addr i with expected value from the image
    task automatic load_vecs(input logic [7:0] img[16]);
        for (int i = 0; i < 16; i++) begin
            vecs[i].addr = 4'(i);
            vecs[i].exp  = img[i];
        end
    endtask

    task automatic run_vecs(input string name);
        for (int i = 0; i < 16; i++) rd(vecs[i].addr, vecs[i].exp, name);
    endtask

    // Launch a sweep; count busy cycles, done pulses and the first done sample index
    task automatic sweep(input logic [3:0] sa, input logic [3:0] ea, input logic [3:0] st,
                         input logic [7:0] fd, output int bcnt, output int dcnt, output int dpos);
        start_addr = sa; end_addr = ea; stride = st; fill_data = fd; start = 1'b1;
        step();
        start = 1'b0;
        bcnt = 0; dcnt = 0; dpos = -1;
        for (int c = 0; c < 30; c++) begin
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (dpos < 0) dpos = c;
            end
            step();
        end
    endtask

    initial begin
        logic [7:0] img[16];
        int bc, dc, dp;

        rst_n = 1'b0; start = 1'b0; wr_en = 1'b0;
        start_addr = '0; end_addr = '0; stride = '0; fill_data = '0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        step(); step();
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset wr_drop", int'(wr_drop), 0);
        check("reset rd_data", int'(rd_data), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 16; i++) img[i] = 8'h00;
        load_vecs(img);
        run_vecs("post-reset");

        // 2..5 stride 1
        sweep(4'd2, 4'd5, 4'd1, 8'hA5, bc, dc, dp);
        check("s1 busy cycles", bc, 4);
        check("s1 done pulses", dc, 1);
        check("s1 done position", dp, 4);
        for (int i = 2; i <= 5; i++) img[i] = 8'hA5;
        load_vecs(img);
        run_vecs("s1");

        // 1..15 stride 4: 1,5,9,13 only
        sweep(4'd1, 4'd15, 4'd4, 8'h3C, bc, dc, dp);
        check("s2 busy cycles", bc, 4);
        check("s2 done pulses", dc, 1);
        img[1] = 8'h3C; img[5] = 8'h3C; img[9] = 8'h3C; img[13] = 8'h3C;
        load_vecs(img);
        run_vecs("s2");

        // start > end: no write, done right after start
        sweep(4'd9, 4'd3, 4'd1, 8'hFF, bc, dc, dp);
        check("s3 busy cycles", bc, 0);
        check("s3 done pulses", dc, 1);
        check("s3 done position", dp, 0);

        // stride 0 treated as 1
        sweep(4'd14, 4'd15, 4'd0, 8'h5A, bc, dc, dp);
        check("s4 busy cycles", bc, 2);
        img[14] = 8'h5A; img[15] = 8'h5A;

        // overshoot past DEPTH must stop, not wrap
        sweep(4'd12, 4'd15, 4'd4, 8'h77, bc, dc, dp);
        check("s5 busy cycles", bc, 1);
        check("s5 done pulses", dc, 1);
        img[12] = 8'h77;
        load_vecs(img);
        run_vecs("s4s5");

        // direct write during FILL is dropped
        start_addr = 4'd8; end_addr = 4'd11; stride = 4'd1; fill_data = 8'h11; start = 1'b1;
        step();
        start = 1'b0; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h99;
        step();
        wr_en = 1'b0;
        check("drop wr_drop pulse", int'(wr_drop), 1);
        step();
        check("drop wr_drop clears", int'(wr_drop), 0);
        bc = 0;
        while (!done && bc < 20) begin step(); bc++; end
        check("drop sweep finished", int'(done), 1);
        step();
        for (int i = 8; i <= 11; i++) img[i] = 8'h11;
        rd(4'd7, 8'h00, "drop");
        rd(4'd8, 8'h11, "drop");

        // same write in IDLE commits; same-cycle read sees old value
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h99; rd_addr = 4'd7;
        step();
        wr_en = 1'b0;
        check("idle wr old value", int'(rd_data), 0);
        check("idle wr no drop", int'(wr_drop), 0);
        step();
        check("idle wr new value", int'(rd_data), 8'h99);

        // reset in the 2nd fill cycle of a 0..15 sweep
        start_addr = 4'd0; end_addr = 4'd15; stride = 4'd1; fill_data = 8'hEE; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        bc = 0; dc = 0;
        for (int c = 0; c < 20; c++) begin
            if (busy) bc++;
            if (done) dc++;
            step();
        end
        check("abort no busy later", bc, 0);
        check("abort no done later", dc, 0);
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
        load_vecs(img);
        run_vecs("abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
